blake2_io_stream: RTL and testbench

//  Parametrised host-side ingress for the BLAKE2 core: decodes the 2-bit command

---
 rtl/blake2_io_stream.sv | 143 ++++++++++++++
 tb/tb_blake2_io_stream.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/blake2_io_stream.sv
// blake2_io_stream: host-side ingress for the BLAKE2 core.
// Decodes the 2-bit command stream, captures the kk/nn/ll configuration and
// forwards data beats with a block-relative beat index and first/last flags.
// Optional protocol checker enabled by defining BLAKE2_IO_PROTO_CHECK_EN.
module blake2_io_stream #(
  parameter int unsigned BUS_W = 1,
  parameter int unsigned BB    = 64,
  parameter int unsigned LL_W  = 64,
  localparam int unsigned IDX_W = $clog2(BB / BUS_W)
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 en_i,
  input  logic                 valid_i,
  input  logic [1:0]           cmd_i,
  input  logic [8*BUS_W-1:0]   data_i,
  input  logic                 ready_v_i,
  input  logic                 hash_v_i,
  input  logic [8*BUS_W-1:0]   hash_i,
  output logic                 ready_v_o,
  output logic                 hash_v_o,
  output logic [8*BUS_W-1:0]   hash_o,
  output logic [6:0]           kk_o,
  output logic [6:0]           nn_o,
  output logic [LL_W-1:0]      ll_o,
  output logic                 data_v_o,
  output logic [8*BUS_W-1:0]   data_o,
  output logic [IDX_W-1:0]     data_idx_o,
  output logic                 block_first_o,
  output logic                 block_last_o,
  output logic                 err_o
);

  localparam int unsigned BEATS   = BB / BUS_W;
  localparam int unsigned CFG_MAX = 2 + LL_W / 8;
  localparam int unsigned CFG_W   = $clog2(CFG_MAX + 1);

  localparam logic [1:0] CMD_CONF  = 2'd0;
  localparam logic [1:0] CMD_START = 2'd1;
  localparam logic [1:0] CMD_DATA  = 2'd2;
  localparam logic [1:0] CMD_LAST  = 2'd3;

  logic             en_q;
  logic             valid;
  logic             is_conf;
  logic             first_beat;
  logic             last_beat;
  logic [CFG_W-1:0] cfg_cnt;
  logic [IDX_W-1:0] beat_cnt;

  assign valid      = en_q & valid_i;
  assign is_conf    = (cmd_i == CMD_CONF);
  assign first_beat = (beat_cnt == IDX_W'(0));
  assign last_beat  = (beat_cnt == IDX_W'(BEATS - 1));

  // Core-facing passthroughs and ready qualification.
  assign ready_v_o = ready_v_i & ~data_v_o;
  assign hash_v_o  = hash_v_i;
  assign hash_o    = hash_i;

  // Slice enable is registered once before it qualifies valid_i.
  always_ff @(posedge clk) begin
    if (!nreset) en_q <= 1'b0;
    else         en_q <= en_i;
  end

  // Configuration capture: kk, nn, then ll bytes shifted in LSB byte first.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      kk_o    <= '0;
      nn_o    <= '0;
      ll_o    <= '0;
      cfg_cnt <= '0;
    end else if (valid) begin
      if (is_conf) begin
        if (cfg_cnt == CFG_W'(0))            kk_o <= data_i[6:0];
        else if (cfg_cnt == CFG_W'(1))       nn_o <= data_i[6:0];
        else if (cfg_cnt < CFG_W'(CFG_MAX))  ll_o <= {data_i[7:0], ll_o[LL_W-1:8]};
        if (cfg_cnt != CFG_W'(CFG_MAX))      cfg_cnt <= cfg_cnt + CFG_W'(1);
      end else begin
        cfg_cnt <= '0;
      end
    end
  end

  // Data beat register, block beat counter and block flags.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      data_v_o      <= 1'b0;
      data_o        <= '0;
      data_idx_o    <= '0;
      beat_cnt      <= '0;
      block_first_o <= 1'b0;
      block_last_o  <= 1'b0;
    end else begin
      data_v_o <= 1'b0;
      if (valid) begin
        if (is_conf) begin
          beat_cnt <= '0;
        end else begin
          data_v_o   <= 1'b1;
          data_o     <= data_i;
          data_idx_o <= beat_cnt;
          beat_cnt   <= last_beat ? IDX_W'(0) : beat_cnt + IDX_W'(1);
          if (first_beat) begin
            block_first_o <= (cmd_i == CMD_START);
            block_last_o  <= (cmd_i == CMD_LAST);
          end
        end
      end
    end
  end

`ifdef BLAKE2_IO_PROTO_CHECK_EN
  logic msg_open;
  logic blk_last_eff;

  // Last-block status of the beat being accepted (flag is updated on idx 0).
  assign blk_last_eff = first_beat ? (cmd_i == CMD_LAST) : block_last_o;

  // Track open message and latch sticky protocol errors.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      msg_open <= 1'b0;
      err_o    <= 1'b0;
    end else if (valid) begin
      if ((is_conf && !first_beat) ||
          (cmd_i == CMD_START && first_beat && msg_open) ||
          (cmd_i == CMD_DATA && first_beat && !msg_open))
        err_o <= 1'b1;
      if (is_conf)
        msg_open <= 1'b0;
      else if (last_beat && blk_last_eff)
        msg_open <= 1'b0;
      else if (first_beat && (cmd_i == CMD_START || cmd_i == CMD_LAST))
        msg_open <= 1'b1;
    end
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_blake2_io_stream.sv
// Directed bench for blake2_io_stream: byte-wide BLAKE2s instance and
// 4-byte-wide BLAKE2b instance, all expectations hand-computed.
module tb_blake2_io_stream;

  localparam logic [1:0] CONF  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] LAST  = 2'd3;

`ifdef BLAKE2_IO_PROTO_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance 0: BUS_W=1, BB=64
  logic        en0, v0, rdy0_i, hv0_i;
  logic [1:0]  cmd0;
  logic [7:0]  d0, h0_i;
  logic        rdy0, hv0, dv0, bf0, bl0, err0;
  logic [7:0]  h0, do0;
  logic [6:0]  kk0, nn0;
  logic [63:0] ll0;
  logic [5:0]  idx0;

  // Instance 1: BUS_W=4, BB=128
  logic        en1, v1, rdy1_i, hv1_i;
  logic [1:0]  cmd1;
  logic [31:0] d1, h1_i;
  logic        rdy1, hv1, dv1, bf1, bl1, err1;
  logic [31:0] h1, do1;
  logic [6:0]  kk1, nn1;
  logic [63:0] ll1;
  logic [4:0]  idx1;

  blake2_io_stream #(.BUS_W(1), .BB(64), .LL_W(64)) u0 (
    .clk(clk), .nreset(nreset), .en_i(en0), .valid_i(v0), .cmd_i(cmd0),
    .data_i(d0), .ready_v_i(rdy0_i), .hash_v_i(hv0_i), .hash_i(h0_i),
    .ready_v_o(rdy0), .hash_v_o(hv0), .hash_o(h0), .kk_o(kk0), .nn_o(nn0),
    .ll_o(ll0), .data_v_o(dv0), .data_o(do0), .data_idx_o(idx0),
    .block_first_o(bf0), .block_last_o(bl0), .err_o(err0));

  blake2_io_stream #(.BUS_W(4), .BB(128), .LL_W(64)) u1 (
    .clk(clk), .nreset(nreset), .en_i(en1), .valid_i(v1), .cmd_i(cmd1),
    .data_i(d1), .ready_v_i(rdy1_i), .hash_v_i(hv1_i), .hash_i(h1_i),
    .ready_v_o(rdy1), .hash_v_o(hv1), .hash_o(h1), .kk_o(kk1), .nn_o(nn1),
    .ll_o(ll1), .data_v_o(dv1), .data_o(do1), .data_idx_o(idx1),
    .block_first_o(bf1), .block_last_o(bl1), .err_o(err1));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat0(input logic [1:0] c, input logic [7:0] d);
    v0 = 1'b1; cmd0 = c; d0 = d;
    tick(1);
    v0 = 1'b0;
  endtask

  task automatic beat1(input logic [1:0] c, input logic [31:0] d);
    v1 = 1'b1; cmd1 = c; d1 = d;
    tick(1);
    v1 = 1'b0;
  endtask

  initial begin
    logic [7:0] cfg [0:10];
    logic [31:0] w;
    cfg = '{8'h20, 8'h20, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
    nreset = 1'b0;
    en0 = 1'b0; v0 = 1'b0; cmd0 = CONF; d0 = '0; rdy0_i = 1'b0; hv0_i = 1'b0; h0_i = '0;
    en1 = 1'b0; v1 = 1'b0; cmd1 = CONF; d1 = '0; rdy1_i = 1'b0; hv1_i = 1'b0; h1_i = '0;
    tick(2);

    // Reset state
    check("rst_dv", 64'(dv0), 64'd0);
    check("rst_idx", 64'(idx0), 64'd0);
    check("rst_kk", 64'(kk0), 64'd0);
    check("rst_ll", ll0, 64'd0);
    check("rst_flags", 64'({bf0, bl0}), 64'd0);
    check("rst_err", 64'(err0), 64'd0);

    nreset = 1'b1; en0 = 1'b1; en1 = 1'b1;
    tick(1);

    // Combinational passthroughs
    hv0_i = 1'b1; h0_i = 8'hA5; rdy0_i = 1'b1;
    #1;
    check("hash_v", 64'(hv0), 64'd1);
    check("hash", 64'(h0), 64'hA5);
    check("ready_idle", 64'(rdy0), 64'd1);
    hv0_i = 1'b0;

    // Config: kk=32 nn=32 ll=64, trailing byte ignored
    for (int i = 0; i < 11; i++) beat0(CONF, cfg[i]);
    check("conf_dv", 64'(dv0), 64'd0);
    check("kk", 64'(kk0), 64'd32);
    check("nn", 64'(nn0), 64'd32);
    check("ll", ll0, 64'd64);

    // START + 63 DATA, BUS_W=1 BB=64
    for (int i = 0; i < 64; i++) begin
      beat0((i == 0) ? START : DATA, 8'(i + 1));
      check($sformatf("blk_dv%0d", i), 64'(dv0), 64'd1);
      check($sformatf("blk_idx%0d", i), 64'(idx0), 64'(i));
      check($sformatf("blk_data%0d", i), 64'(do0), 64'(i + 1));
      check($sformatf("blk_flags%0d", i), 64'({bf0, bl0}), 64'b10);
      if (i == 0) check("ready_busy", 64'(rdy0), 64'd0);
    end
    tick(1);
    check("hold_dv", 64'(dv0), 64'd0);
    check("hold_data", 64'(do0), 64'd64);
    check("hold_idx", 64'(idx0), 64'd63);

    // Second block, then en_i low during 5 beats
    for (int i = 0; i < 3; i++) beat0(DATA, 8'(8'h80 + i));
    check("blk2_idx", 64'(idx0), 64'd2);
    check("blk2_flags", 64'({bf0, bl0}), 64'b00);
    en0 = 1'b0;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      beat0(DATA, 8'hEE);
      check($sformatf("en_dv%0d", i), 64'(dv0), 64'd0);
      check($sformatf("en_idx%0d", i), 64'(idx0), 64'd2);
    end
    en0 = 1'b1;
    tick(1);
    beat0(DATA, 8'h83);
    check("resume_idx", 64'(idx0), 64'd3);
    check("resume_data", 64'(do0), 64'h83);
    for (int i = 4; i <= 17; i++) beat0(DATA, 8'(i));
    check("pre_rst_idx", 64'(idx0), 64'd17);

    // Reset mid-block
    nreset = 1'b0;
    tick(1);
    check("mrst_idx", 64'(idx0), 64'd0);
    check("mrst_data", 64'(do0), 64'd0);
    check("mrst_kk", 64'({kk0, nn0}), 64'd0);
    check("mrst_ll", ll0, 64'd0);
    check("mrst_flags", 64'({bf0, bl0, dv0}), 64'd0);
    nreset = 1'b1;
    tick(1);
    beat0(START, 8'h11);
    check("fresh_dv", 64'(dv0), 64'd1);
    check("fresh_idx", 64'(idx0), 64'd0);
    check("fresh_first", 64'(bf0), 64'd1);

    // CONF at idx 5 restarts the message
    for (int i = 1; i <= 4; i++) beat0(DATA, 8'(i));
    check("c5_idx", 64'(idx0), 64'd4);
    beat0(CONF, 8'h0A);
    check("c5_kk", 64'(kk0), 64'd10);
    check("c5_err", 64'(err0), 64'(CHK));
    tick(3);
    check("c5_err_sticky", 64'(err0), 64'(CHK));
    beat0(START, 8'h22);
    check("c5_restart_idx", 64'(idx0), 64'd0);

    // BUS_W=4 BB=128: 32 LAST beats, wrap to fresh block
    for (int i = 0; i < 32; i++) begin
      w = {8'(4*i + 3), 8'(4*i + 2), 8'(4*i + 1), 8'(4*i)};
      beat1(LAST, w);
      check($sformatf("b_idx%0d", i), 64'(idx1), 64'(i));
      check($sformatf("b_data%0d", i), 64'(do1), 64'(w));
      check($sformatf("b_flags%0d", i), 64'({bf1, bl1}), 64'b01);
    end
    check("b_err", 64'(err1), 64'd0);
    beat1(DATA, 32'hDEADBEEF);
    check("b_wrap_idx", 64'(idx1), 64'd0);
    check("b_wrap_flags", 64'({bf1, bl1}), 64'b00);
    check("b_wrap_data", 64'(do1), 64'hDEADBEEF);
    check("b_data_err", 64'(err1), 64'(CHK));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
